// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the sequential ALU.
package alu_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_PASSA = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 3'd2;
  localparam logic [OP_W-1:0] OP_INC   = 3'd3;
  localparam logic [OP_W-1:0] OP_SHR   = 3'd4;
  localparam logic [OP_W-1:0] OP_MUL   = 3'd5;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd6;
  localparam logic [OP_W-1:0] OP_CLR   = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per step_en.
// result is the post-step value so the caller can capture it on the last step.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step_en,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(ITER);

  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem_sh;
  logic [CNT_W-1:0] cnt;
  logic             is_div;

  assign is_div = (op_q == OP_DIV);
  assign last   = step_en && (cnt == CNT_W'(ITER - 1));
  assign result = is_div ? q_nxt : acc_nxt;

  // acc is the product accumulator (MUL) or partial remainder (DIV);
  // q is the shifting multiplier (MUL) or dividend/quotient (DIV).
  always_comb begin
    acc_nxt   = acc;
    q_nxt     = q;
    mcand_nxt = mcand;
    rem_sh    = {acc, q[WIDTH-1]};
    if (is_div) begin
      if (rem_sh >= {1'b0, divisor}) begin
        acc_nxt = WIDTH'(rem_sh - {1'b0, divisor});
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (q[0]) begin
        acc_nxt = acc + mcand;
      end
      mcand_nxt = {mcand[WIDTH-2:0], 1'b0};
      q_nxt     = {1'b0, q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_PASSA;
      acc     <= '0;
      q       <= '0;
      mcand   <= '0;
      divisor <= '0;
      cnt     <= '0;
    end else if (load) begin
      op_q    <= op;
      acc     <= '0;
      q       <= (op == OP_DIV) ? a : b;
      mcand   <= a;
      divisor <= b;
      cnt     <= '0;
    end else if (step_en) begin
      acc   <= acc_nxt;
      q     <= q_nxt;
      mcand <= mcand_nxt;
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative MUL/DIV
// behind a start/busy/done handshake, with a shared registered result.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_bus,
  input  logic [WIDTH-1:0] B_bus,
  input  logic [2:0]       alu_op,
  input  logic             start,
  output logic [WIDTH-1:0] C_bus,
  output logic             busy,
  output logic             done,
  output logic             z_flag,
  output logic             c_flag
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic             is_iter;
  logic             md_load, md_step, md_last;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cf;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             wr;
  logic [WIDTH-1:0] res_nxt;
  logic             cf_nxt;

  assign is_iter = (alu_op == OP_MUL) || (alu_op == OP_DIV);

  // Single-cycle datapath; ADD carry and SUB borrow come from bit WIDTH.
  always_comb begin
    sum_ext  = {1'b0, A_bus} + {1'b0, B_bus};
    diff_ext = {1'b0, A_bus} - {1'b0, B_bus};
    sc_res   = '0;
    sc_cf    = 1'b0;
    case (alu_op)
      OP_PASSA: sc_res = A_bus;
      OP_ADD: begin
        sc_res = sum_ext[WIDTH-1:0];
        sc_cf  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        sc_res = diff_ext[WIDTH-1:0];
        sc_cf  = diff_ext[WIDTH];
      end
      OP_INC:  sc_res = A_bus + WIDTH'(1);
      OP_SHR:  sc_res = A_bus >> B_bus[SH_W-1:0];
      default: sc_res = '0;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .load    (md_load),
    .op      (alu_op),
    .a       (A_bus),
    .b       (B_bus),
    .step_en (md_step),
    .last    (md_last),
    .result  (md_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && is_iter) state_nxt = RUN;
      RUN:  if (md_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // start is only looked at in IDLE, so requests during RUN are dropped.
  always_comb begin
    md_load = 1'b0;
    md_step = 1'b0;
    wr      = 1'b0;
    res_nxt = '0;
    cf_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_iter) begin
            md_load = 1'b1;
          end else begin
            wr      = 1'b1;
            res_nxt = sc_res;
            cf_nxt  = sc_cf;
          end
        end
      end
      RUN: begin
        md_step = 1'b1;
        if (md_last) begin
          wr      = 1'b1;
          res_nxt = md_result;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C_bus  <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= wr;
      busy <= (state_nxt == RUN);
      if (wr) begin
        C_bus  <= res_nxt;
        z_flag <= (res_nxt == '0);
        c_flag <= cf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a monitor
// pops and compares on every done pulse, including the cycle it arrived in.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A_bus, B_bus;
  logic [2:0]  alu_op;
  logic        start;
  logic [15:0] C_bus;
  logic        busy, done, z_flag, c_flag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] c;
    logic        z;
    logic        cf;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  alu_seq dut (
    .clk    (clk),
    .rst    (rst),
    .A_bus  (A_bus),
    .B_bus  (B_bus),
    .alu_op (alu_op),
    .start  (start),
    .C_bus  (C_bus),
    .busy   (busy),
    .done   (done),
    .z_flag (z_flag),
    .c_flag (c_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got C=%0h with nothing expected (cycle %0d)", C_bus, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("c_bus", 32'(C_bus), 32'(e.c));
        chk("z_flag", 32'(z_flag), 32'(e.z));
        chk("c_flag", 32'(c_flag), 32'(e.cf));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push(input logic [15:0] c, input logic z, input logic cf, input int at);
    exp_t e;
    e.c = c; e.z = z; e.cf = cf; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no done, expected %0d pending results", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ec, input logic ez, input logic ecf);
    int  m;
    bit  multi;
    multi = (op == OP_MUL) || (op == OP_DIV);
    @(negedge clk);
    A_bus = a; B_bus = b; alu_op = op; start = 1'b1;
    m = cyc;
    push(ec, ez, ecf, m + (multi ? 17 : 1));
    @(negedge clk);
    start = 1'b0;
    A_bus = a ^ 16'h5A5A;
    B_bus = b ^ 16'h00FF;
    if (multi) begin
      for (int k = 1; k <= 17; k++) begin
        chk("busy", 32'(busy), 32'(k <= 16));
        if (k < 17) begin
          @(negedge clk);
          A_bus = 16'($urandom);
        end
      end
    end
    wait_drain();
  endtask

  initial begin
    int m;
    rst = 1'b1; A_bus = '0; B_bus = '0; alu_op = OP_PASSA; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_c_bus", 32'(C_bus), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_flags", 32'({z_flag, c_flag}), 32'h0);
    rst = 1'b0;

    run_op(OP_ADD,   16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b1);
    run_op(OP_SUB,   16'd5,    16'd5,    16'h0000, 1'b1, 1'b0);
    run_op(OP_SUB,   16'd3,    16'd5,    16'hFFFE, 1'b0, 1'b1);
    run_op(OP_SHR,   16'h8000, 16'd4,    16'h0800, 1'b0, 1'b0);
    run_op(OP_INC,   16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(OP_CLR,   16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0);
    run_op(OP_PASSA, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0);

    // Reset in cycle 5 of a MUL: outputs clear, no done for the aborted op.
    @(negedge clk);
    A_bus = 16'd300; B_bus = 16'd200; alu_op = OP_MUL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_c_bus", 32'(C_bus), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_flags", 32'({z_flag, c_flag}), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run_op(OP_ADD, 16'd3, 16'd4, 16'd7, 1'b0, 1'b0);

    run_op(OP_MUL, 16'd300,  16'd200,  16'hEA60, 1'b0, 1'b0);
    run_op(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
    run_op(OP_DIV, 16'd1000, 16'd4,    16'd250,  1'b0, 1'b0);
    run_op(OP_DIV, 16'd7,    16'd0,    16'hFFFF, 1'b0, 1'b0);
    run_op(OP_DIV, 16'd65535, 16'd255, 16'd257,  1'b0, 1'b0);

    // start held for 20 cycles: one MUL result at 17, a DIV accepted in that
    // done cycle completes at 34, and bus toggling during RUN is ignored.
    @(negedge clk);
    m = cyc;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin
        A_bus = 16'd300; B_bus = 16'd200; alu_op = OP_MUL;
        push(16'hEA60, 1'b0, 1'b0, m + 17);
      end else if (k == 17) begin
        A_bus = 16'd1000; B_bus = 16'd4; alu_op = OP_DIV;
        push(16'd250, 1'b0, 1'b0, m + 34);
      end else begin
        A_bus = 16'($urandom);
        B_bus = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
